sysram_arb: RTL and testbench
=============================

Name: sysram_arb

Overview:
- Two-requester arbiter sharing the single-port system RAM.
- Requester 0 is the CPU load/store unit; requester 1 is the DMA/loader engine.
- Each requester gets a request/grant handshake and a qualified read-return path.
- The block registers the winning command onto the RAM port: 2-cycle read latency, one access per cycle throughput.

Parameters:
BYTE, 8, machine byte size (bits)
BYTE_CNT, 4, bytes per machine word
WORD, 32, machine word size (bits); must equal BYTE*BYTE_CNT
ADDRW, 14, RAM word-address width (bits)
MAX_HOLD, 16, max consecutive locked grants to one requester while the other waits; range 1..255

Ports:
clk  in  1  system clock (single clock domain)
rst_n  in  1  asynchronous active-low reset
req0  in  1  requester 0 access request
lock0  in  1  requester 0 wants to keep the grant for a burst
we0  in  BYTE_CNT  requester 0 byte write enables; all zero = read
addr0  in  ADDRW  requester 0 word address
din0  in  WORD  requester 0 write data
gnt0  out  1  requester 0 command accepted this cycle (when req0 high)
rvalid0  out  1  read data for requester 0 valid on rdata
req1, lock1, we1, addr1, din1, gnt1, rvalid1: as above, requester 1
rdata  out  WORD  read data, shared; qualified by rvalidN
mem_we  out  BYTE_CNT  to RAM write enable
mem_re  out  1  to RAM read enable
mem_addr  out  ADDRW  to RAM address
mem_din  out  WORD  to RAM write data
mem_dout  in  WORD  from RAM read data

Behaviour:
- Reset: gnt0/gnt1 low while rst_n low. All of the following clear to 0 asynchronously:
  - mem_we, mem_re, mem_addr, mem_din
  - rvalid0/1, owner pipeline, hold counter
  - priority pointer (points to requester 0)
- Grant is combinational from current inputs and registered state.
  - At most one gnt high per cycle.
  - gntN never high unless reqN high.
- Acceptance: reqN & gntN in cycle T.
  - Command registers onto mem_* at the edge ending T.
  - RAM samples at the edge ending T+1.
  - For reads, rvalidN and rdata = mem_dout are valid in cycle T+2.
- Cycles with no acceptance drive mem_we=0 and mem_re=0. mem_addr and mem_din hold their last value.
- Read: weN==0 gives mem_re=1, mem_we=0.
- Write: weN!=0 gives mem_we=weN, mem_re=0. No rvalid is issued; RAM dout is unchanged (no-change mode).
- Owner pipeline: 2-stage shift of {valid_read, id}.
  - rvalidN = stage2 valid & stage2 id==N.
  - rdata passes through from mem_dout, unregistered.
- Arbitration states:
  - IDLE: no current owner.
  - OWN0 / OWN1: last grant went to requester 0/1 with lockN high.
- From IDLE, or when the owner drops lock: pick the winner by the arbitration policy (see Optional Feature).
- In OWNn with lockn & reqn high: grant n again and increment hold counter. Exception: if the other requester is waiting and hold count == MAX_HOLD, grant the other, move to its OWN/IDLE state and clear the counter.
- Owner drops req or lock: return to IDLE; the counter clears on any change of owner.
- Requests are level-held. A requester must keep req/we/addr/din stable until gnt; deasserting before gnt is allowed (request withdrawn).
- Reset mid-operation: in-flight reads are discarded; no rvalid appears after reset release.
- The hold counter is width clog2(MAX_HOLD+1) and saturates, never wrapping.

Optional Feature:
- Macro: SYSRAM_ARB_RR_EN.
- Defined: round-robin arbitration.
  - On contention from IDLE, the requester not granted last wins.
  - The priority pointer updates on every acceptance.
- Undefined: fixed priority, requester 0 wins all contention from IDLE.
  - The pointer register is not instantiated.
  - MAX_HOLD still bounds locked bursts from either requester.

Decomposition:
- Shared constants header (sysram_defs.vh) holds:
  - requester IDs (REQ_CPU=0, REQ_DMA=1)
  - arbiter state encodings (IDLE, OWN0, OWN1)
- One sub-module, arb2_pick: a combinational 2-way pick from req vectors, priority pointer and current owner/lock. It is reused by future VRAM arbiters.
- The owner pipeline and hold counter stay in sysram_arb.

Test Plan:
- Reset/idle: rst_n low 3 cycles, then high with no req -> all outputs 0; mem_re=mem_we=0 for 10 cycles.
- Read latency: req0 read addr=0x0010 with RAM word 0xDEADBEEF -> gnt0 same cycle; mem_re=1, mem_addr=0x0010 next cycle; rvalid0=1 with rdata=0xDEADBEEF two cycles after grant; rvalid1 stays 0.
- Byte write: req1 we=4'b0100 addr=0x0020 din=0x00AB0000, then read it back -> mem_we=4'b0100 for exactly one cycle; only byte 2 is changed on readback.
- Contention: req0 and req1 both held for 8 cycles, no lock -> with RR_EN grants alternate 0,1,0,1...; without it, gnt0 all 8 cycles.
- Lock bound: MAX_HOLD=4, lock0 and req0 held, req1 asserted -> exactly 4 consecutive gnt0 after req1 rises, then gnt1.
- Reset mid-read: assert rst_n low one cycle after gnt0 on a read -> no rvalid0 ever appears; the first post-reset grant behaves as in the Read latency scenario.

Source files
------------

// File: rtl/sysram_arb_pkg.sv
// Shared definitions for the system RAM arbiter: requester IDs and arbiter state encoding.
package sysram_arb_pkg;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DMA = 1'b1;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StOwn0 = 2'd1,
    StOwn1 = 2'd2
  } arb_state_e;

  function automatic arb_state_e own_state(logic id);
    return id ? StOwn1 : StOwn0;
  endfunction

endpackage

// File: rtl/sysram_arb_arb2_pick.sv
// Combinational 2-way pick: a locked owner keeps the grant unless its hold limit is hit
// while the other requester waits; otherwise contention is resolved by prio_i.
module arb2_pick (
  input  logic [1:0] req_i,
  input  logic [1:0] lock_i,
  input  logic       prio_i,
  input  logic       own_vld_i,
  input  logic       own_id_i,
  input  logic       limit_i,
  output logic [1:0] gnt_o
);

  logic other;

  always_comb begin
    other = ~own_id_i;
    gnt_o = 2'b00;
    if (own_vld_i && req_i[own_id_i] && lock_i[own_id_i]) begin
      if (limit_i && req_i[other]) begin
        gnt_o[other] = 1'b1;
      end else begin
        gnt_o[own_id_i] = 1'b1;
      end
    end else if (req_i == 2'b11) begin
      gnt_o[prio_i] = 1'b1;
    end else begin
      gnt_o = req_i;
    end
  end

endmodule

// File: rtl/sysram_arb.sv
// Two-requester arbiter for the single-port system RAM (CPU = 0, DMA = 1).
// Define SYSRAM_ARB_RR_EN for round-robin contention; default is fixed priority to requester 0.
module sysram_arb
  import sysram_arb_pkg::*;
#(
  parameter int unsigned BYTE     = 8,
  parameter int unsigned BYTE_CNT = 4,
  parameter int unsigned WORD     = 32,
  parameter int unsigned ADDRW    = 14,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req0,
  input  logic                lock0,
  input  logic [BYTE_CNT-1:0] we0,
  input  logic [ADDRW-1:0]    addr0,
  input  logic [WORD-1:0]     din0,
  output logic                gnt0,
  output logic                rvalid0,
  input  logic                req1,
  input  logic                lock1,
  input  logic [BYTE_CNT-1:0] we1,
  input  logic [ADDRW-1:0]    addr1,
  input  logic [WORD-1:0]     din1,
  output logic                gnt1,
  output logic                rvalid1,
  output logic [WORD-1:0]     rdata,
  output logic [BYTE_CNT-1:0] mem_we,
  output logic                mem_re,
  output logic [ADDRW-1:0]    mem_addr,
  output logic [WORD-1:0]     mem_din,
  input  logic [WORD-1:0]     mem_dout
);

  localparam int unsigned HoldW = $clog2(MAX_HOLD + 1);

  if (WORD != BYTE * BYTE_CNT) begin : g_bad_word
    $error("sysram_arb: WORD must equal BYTE*BYTE_CNT");
  end

  arb_state_e          state_q, state_d;
  logic [HoldW-1:0]    hold_q, hold_d;
  logic                s1_vld_q, s1_vld_d, s1_id_q, s1_id_d;
  logic                s2_vld_q, s2_id_q;
  logic [BYTE_CNT-1:0] mem_we_d;
  logic                mem_re_d;
  logic [ADDRW-1:0]    mem_addr_d;
  logic [WORD-1:0]     mem_din_d;

  logic [1:0]          gnt_raw;
  logic                prio, own_vld, own_id, limit, acc, acc_id, keep;
  logic [BYTE_CNT-1:0] sel_we;

  assign own_vld = (state_q != StIdle);
  assign own_id  = (state_q == StOwn1);
  assign limit   = (hold_q == HoldW'(MAX_HOLD));

`ifdef SYSRAM_ARB_RR_EN
  logic ptr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= REQ_CPU;
    end else if (acc) begin
      ptr_q <= ~acc_id;
    end
  end

  assign prio = ptr_q;
`else
  assign prio = REQ_CPU;
`endif

  arb2_pick u_pick (
    .req_i     ({req1, req0}),
    .lock_i    ({lock1, lock0}),
    .prio_i    (prio),
    .own_vld_i (own_vld),
    .own_id_i  (own_id),
    .limit_i   (limit),
    .gnt_o     (gnt_raw)
  );

  // Grants are forced low while reset is asserted.
  assign gnt0   = gnt_raw[0] & rst_n;
  assign gnt1   = gnt_raw[1] & rst_n;
  assign acc    = gnt0 | gnt1;
  assign acc_id = gnt1 ? REQ_DMA : REQ_CPU;
  assign sel_we = acc_id ? we1 : we0;

  // Counter only runs while the same owner is re-granted and the other side is waiting.
  assign keep = own_vld && acc && (acc_id == own_id) && (own_id ? req0 : req1);

  always_comb begin
    state_d    = StIdle;
    hold_d     = '0;
    mem_we_d   = '0;
    mem_re_d   = 1'b0;
    mem_addr_d = mem_addr;
    mem_din_d  = mem_din;
    s1_vld_d   = 1'b0;
    s1_id_d    = acc_id;
    if (acc) begin
      state_d    = (acc_id ? lock1 : lock0) ? own_state(acc_id) : StIdle;
      mem_we_d   = sel_we;
      mem_re_d   = (sel_we == '0);
      mem_addr_d = acc_id ? addr1 : addr0;
      mem_din_d  = acc_id ? din1 : din0;
      s1_vld_d   = (sel_we == '0);
    end
    if (keep) begin
      hold_d = limit ? hold_q : hold_q + HoldW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      hold_q   <= '0;
      s1_vld_q <= 1'b0;
      s1_id_q  <= 1'b0;
      s2_vld_q <= 1'b0;
      s2_id_q  <= 1'b0;
      mem_we   <= '0;
      mem_re   <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      s1_vld_q <= s1_vld_d;
      s1_id_q  <= s1_id_d;
      s2_vld_q <= s1_vld_q;
      s2_id_q  <= s1_id_q;
      mem_we   <= mem_we_d;
      mem_re   <= mem_re_d;
      mem_addr <= mem_addr_d;
      mem_din  <= mem_din_d;
    end
  end

  assign rvalid0 = s2_vld_q && (s2_id_q == REQ_CPU);
  assign rvalid1 = s2_vld_q && (s2_id_q == REQ_DMA);
  assign rdata   = mem_dout;

endmodule

// File: tb/tb_sysram_arb.sv
// Directed bench for sysram_arb with a small synchronous no-change RAM model.
module tb_sysram_arb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 1'b0, lock0 = 1'b0, req1 = 1'b0, lock1 = 1'b0;
  logic [3:0]  we0 = '0, we1 = '0;
  logic [13:0] addr0 = '0, addr1 = '0;
  logic [31:0] din0 = '0, din1 = '0;
  logic        gnt0, gnt1, rvalid0, rvalid1, mem_re;
  logic [31:0] rdata, mem_din;
  logic [31:0] mem_dout = '0;
  logic [3:0]  mem_we;
  logic [13:0] mem_addr;

  logic [31:0] ram [256];
  logic        ram_init = 1'b1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sysram_arb #(
    .BYTE     (8),
    .BYTE_CNT (4),
    .WORD     (32),
    .ADDRW    (14),
    .MAX_HOLD (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req0     (req0),
    .lock0    (lock0),
    .we0      (we0),
    .addr0    (addr0),
    .din0     (din0),
    .gnt0     (gnt0),
    .rvalid0  (rvalid0),
    .req1     (req1),
    .lock1    (lock1),
    .we1      (we1),
    .addr1    (addr1),
    .din1     (din1),
    .gnt1     (gnt1),
    .rvalid1  (rvalid1),
    .rdata    (rdata),
    .mem_we   (mem_we),
    .mem_re   (mem_re),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .mem_dout (mem_dout)
  );

  // Synchronous RAM, dout unchanged on writes.
  always @(posedge clk) begin
    if (ram_init) begin
      ram[8'h10] <= 32'hDEAD_BEEF;
      ram[8'h20] <= 32'h1122_3344;
    end else begin
      if (mem_re) mem_dout <= ram[mem_addr[7:0]];
      for (int b = 0; b < 4; b++) begin
        if (mem_we[b]) ram[mem_addr[7:0]][b*8 +: 8] <= mem_din[b*8 +: 8];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic exp0;

    // Reset held for 3 cycles; a request during reset must not be granted.
    req0 = 1'b1;
    #1;
    chk("rst_gnt0", 32'(gnt0), 32'd0);
    chk("rst_gnt1", 32'(gnt1), 32'd0);
    req0 = 1'b0;
    step();
    ram_init = 1'b0;
    step();
    step();
    chk("rst_mem_re", 32'(mem_re), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_din", mem_din, 32'd0);
    chk("rst_rvalid0", 32'(rvalid0), 32'd0);
    chk("rst_rvalid1", 32'(rvalid1), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("idle_mem_re[%0d]", i), 32'(mem_re), 32'd0);
      chk($sformatf("idle_mem_we[%0d]", i), 32'(mem_we), 32'd0);
    end

    // Read latency from requester 0.
    req0 = 1'b1; we0 = 4'b0000; addr0 = 14'h0010;
    #1;
    chk("rd_gnt0", 32'(gnt0), 32'd1);
    chk("rd_gnt1", 32'(gnt1), 32'd0);
    step();
    req0 = 1'b0;
    chk("rd_mem_re", 32'(mem_re), 32'd1);
    chk("rd_mem_we", 32'(mem_we), 32'd0);
    chk("rd_mem_addr", 32'(mem_addr), 32'h10);
    chk("rd_rvalid0_early", 32'(rvalid0), 32'd0);
    step();
    chk("rd_rvalid0", 32'(rvalid0), 32'd1);
    chk("rd_rdata", rdata, 32'hDEAD_BEEF);
    chk("rd_rvalid1", 32'(rvalid1), 32'd0);
    chk("rd_mem_re_off", 32'(mem_re), 32'd0);
    step();
    chk("rd_rvalid0_once", 32'(rvalid0), 32'd0);

    // Byte write from requester 1, then read back.
    req1 = 1'b1; we1 = 4'b0100; addr1 = 14'h0020; din1 = 32'h00AB_0000;
    #1;
    chk("wr_gnt1", 32'(gnt1), 32'd1);
    chk("wr_gnt0", 32'(gnt0), 32'd0);
    step();
    req1 = 1'b0;
    chk("wr_mem_we", 32'(mem_we), 32'h4);
    chk("wr_mem_re", 32'(mem_re), 32'd0);
    chk("wr_mem_addr", 32'(mem_addr), 32'h20);
    chk("wr_mem_din", mem_din, 32'h00AB_0000);
    step();
    chk("wr_mem_we_once", 32'(mem_we), 32'd0);
    chk("wr_mem_din_hold", mem_din, 32'h00AB_0000);
    step();
    chk("wr_no_rvalid1", 32'(rvalid1), 32'd0);
    req1 = 1'b1; we1 = 4'b0000;
    #1;
    chk("rb_gnt1", 32'(gnt1), 32'd1);
    step();
    req1 = 1'b0;
    step();
    chk("rb_rvalid1", 32'(rvalid1), 32'd1);
    chk("rb_rdata", rdata, 32'h11AB_3344);
    chk("rb_rvalid0", 32'(rvalid0), 32'd0);
    step();

    // Contention without lock; last acceptance was requester 1.
    req0 = 1'b1; we0 = 4'b0000; addr0 = 14'h0010;
    req1 = 1'b1; we1 = 4'b0000; addr1 = 14'h0020;
    for (int i = 0; i < 8; i++) begin
`ifdef SYSRAM_ARB_RR_EN
      exp0 = (i % 2 == 0);
`else
      exp0 = 1'b1;
`endif
      #1;
      chk($sformatf("cont_gnt0[%0d]", i), 32'(gnt0), 32'(exp0));
      chk($sformatf("cont_gnt1[%0d]", i), 32'(gnt1), 32'(!exp0));
      step();
    end
    req0 = 1'b0; req1 = 1'b0;
    step(); step(); step();

    // Locked burst bounded by MAX_HOLD = 4.
    req0 = 1'b1; lock0 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk($sformatf("lock_pre_gnt0[%0d]", i), 32'(gnt0), 32'd1);
      step();
    end
    req1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("lock_gnt0[%0d]", i), 32'(gnt0), 32'd1);
      chk($sformatf("lock_gnt1_off[%0d]", i), 32'(gnt1), 32'd0);
      step();
    end
    #1;
    chk("lock_gnt1", 32'(gnt1), 32'd1);
    chk("lock_gnt0_off", 32'(gnt0), 32'd0);
    step();
    #1;
    chk("lock_after_gnt0", 32'(gnt0), 32'd1);
    req0 = 1'b0; lock0 = 1'b0; req1 = 1'b0;
    step(); step(); step();

    // Reset one cycle after a read grant.
    req0 = 1'b1; we0 = 4'b0000; addr0 = 14'h0010;
    #1;
    chk("mr_gnt0", 32'(gnt0), 32'd1);
    step();
    req0 = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mr_mem_re", 32'(mem_re), 32'd0);
    for (int i = 0; i < 6; i++) begin
      if (i == 2) rst_n = 1'b1;
      step();
      chk($sformatf("mr_no_rvalid0[%0d]", i), 32'(rvalid0), 32'd0);
    end
    req0 = 1'b1;
    #1;
    chk("mr2_gnt0", 32'(gnt0), 32'd1);
    step();
    req0 = 1'b0;
    chk("mr2_mem_re", 32'(mem_re), 32'd1);
    chk("mr2_mem_addr", 32'(mem_addr), 32'h10);
    step();
    chk("mr2_rvalid0", 32'(rvalid0), 32'd1);
    chk("mr2_rdata", rdata, 32'hDEAD_BEEF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
